// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
// Avalon-MM programmable phase accumulator that feeds the 10-bit phase input
// of phase_to_amplitude_converter. Two modes: continuous tone at the live FTW
// register, or a linear frequency sweep from FTW to FTW_END in STEP increments,
// holding each tuning word for DWELL samples.
// Optional feature macro: DDS_SWEEP_IRQ_EN adds the irq output and the
// read/write IRQ mask bit CTRL[4]; without it CTRL[4] reads 0.
module dds_sweep_controller #(
   parameter int ACC_W   = 32,
   parameter int DWELL_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  avs_address,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic [9:0]  phase_out,
   output logic        phase_valid,
`ifdef DDS_SWEEP_IRQ_EN
   output logic        busy,
   output logic        irq
`else
   output logic        busy
`endif
);

   localparam logic [2:0] A_CTRL    = 3'd0;
   localparam logic [2:0] A_FTW     = 3'd1;
   localparam logic [2:0] A_FTW_END = 3'd2;
   localparam logic [2:0] A_STEP    = 3'd3;
   localparam logic [2:0] A_DWELL   = 3'd4;
   localparam logic [2:0] A_STATUS  = 3'd5;
   localparam logic [2:0] A_OFFSET  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_SWEEP = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // Programmable registers
   logic               r_mode;
   logic               r_repeat;
   logic [ACC_W-1:0]   r_ftw;
   logic [ACC_W-1:0]   r_ftw_end;
   logic [ACC_W-1:0]   r_step;
   logic [DWELL_W-1:0] r_dwell;
   logic [9:0]         r_offset;
   logic               w_irq_mask;

   // Sequencer state
   state_t             r_state;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_cur_ftw;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic               r_done;

   // Registered outputs
   logic [9:0]         r_phase_out;
   logic               r_phase_valid;
   logic [31:0]        r_readdata;

   // Decoded bus events
   logic               w_wr_ctrl;
   logic               w_stop;
   logic               w_start;
   logic               w_done_clr;
   logic               w_active;

   // Sweep arithmetic
   logic [ACC_W:0]     w_step_sum;
   logic [ACC_W-1:0]   w_next_ftw;
   logic [DWELL_W-1:0] w_dwell_last;
   logic               w_dwell_exp;
   logic [9:0]         w_phase_next;
   logic [31:0]        w_rd_data;

   assign w_wr_ctrl  = avs_write && (avs_address == A_CTRL);
   assign w_stop     = w_wr_ctrl && avs_writedata[1];
   // STOP has priority when both control bits arrive in the same write
   assign w_start    = w_wr_ctrl && avs_writedata[0] && !avs_writedata[1];
   assign w_done_clr = avs_write && (avs_address == A_STATUS) && avs_writedata[1];
   assign w_active   = (r_state == S_RUN) || (r_state == S_SWEEP);

   // One extra bit on the sum so an overflowing step still clamps to FTW_END
   assign w_step_sum   = {1'b0, r_cur_ftw} + {1'b0, r_step};
   assign w_next_ftw   = (w_step_sum > {1'b0, r_ftw_end}) ? r_ftw_end : w_step_sum[ACC_W-1:0];
   // A DWELL of 0 dwells for one sample, same as 1
   assign w_dwell_last = (r_dwell == '0) ? '0 : (r_dwell - DWELL_W'(1));
   // >= keeps a mid-dwell shrink of DWELL from running the counter around
   assign w_dwell_exp  = (r_dwell_cnt >= w_dwell_last);
   assign w_phase_next = r_acc[ACC_W-1 -: 10] + r_offset;

`ifdef DDS_SWEEP_IRQ_EN
   logic r_irq_mask;
   assign w_irq_mask = r_irq_mask;
   assign irq        = r_done & r_irq_mask;
`else
   assign w_irq_mask = 1'b0;
`endif

   assign busy         = w_active;
   assign phase_out    = r_phase_out;
   assign phase_valid  = r_phase_valid;
   assign avs_readdata = r_readdata;

   // Register file: CPU writes to configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode    <= 1'b0;
         r_repeat  <= 1'b0;
         r_ftw     <= '0;
         r_ftw_end <= '0;
         r_step    <= '0;
         r_dwell   <= '0;
         r_offset  <= 10'd0;
`ifdef DDS_SWEEP_IRQ_EN
         r_irq_mask <= 1'b0;
`endif
      end else if (avs_write) begin
         case (avs_address)
            A_CTRL: begin
               r_mode   <= avs_writedata[2];
               r_repeat <= avs_writedata[3];
`ifdef DDS_SWEEP_IRQ_EN
               r_irq_mask <= avs_writedata[4];
`endif
            end
            A_FTW:     r_ftw     <= avs_writedata[ACC_W-1:0];
            A_FTW_END: r_ftw_end <= avs_writedata[ACC_W-1:0];
            A_STEP:    r_step    <= avs_writedata[ACC_W-1:0];
            A_DWELL:   r_dwell   <= avs_writedata[DWELL_W-1:0];
            A_OFFSET:  r_offset  <= avs_writedata[9:0];
            default:   r_offset  <= r_offset;
         endcase
      end else begin
         r_offset <= r_offset;
      end
   end

   // Read mux: current register contents for the addressed word
   always_comb begin
      w_rd_data = 32'd0;
      case (avs_address)
         A_CTRL:    w_rd_data = {27'd0, w_irq_mask, r_repeat, r_mode, 2'b00};
         A_FTW:     w_rd_data = 32'(r_ftw);
         A_FTW_END: w_rd_data = 32'(r_ftw_end);
         A_STEP:    w_rd_data = 32'(r_step);
         A_DWELL:   w_rd_data = 32'(r_dwell);
         A_STATUS:  w_rd_data = {28'd0, 2'(r_state), r_done, w_active};
         A_OFFSET:  w_rd_data = {22'd0, r_offset};
         default:   w_rd_data = 32'd0;
      endcase
   end

   // Read data register: one-cycle latency, holds between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_readdata <= 32'd0;
      end else if (avs_read) begin
         r_readdata <= w_rd_data;
      end else begin
         r_readdata <= r_readdata;
      end
   end

   // Sequencer FSM with phase accumulator, sweep stepping and output pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_acc         <= '0;
         r_cur_ftw     <= '0;
         r_dwell_cnt   <= '0;
         r_done        <= 1'b0;
         r_phase_out   <= 10'd0;
         r_phase_valid <= 1'b0;
      end else begin
         // Output stage samples the accumulator before this edge's update
         if (w_active) begin
            r_phase_out <= w_phase_next;
         end else begin
            r_phase_out <= r_phase_out;
         end
         r_phase_valid <= w_active && !w_stop;

         // Clear first so a coincident end-of-sweep set below wins
         if (w_done_clr) begin
            r_done <= 1'b0;
         end else begin
            r_done <= r_done;
         end

         if (w_stop) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_dwell_cnt <= '0;
         end else if (w_start) begin
            r_acc       <= '0;
            r_cur_ftw   <= r_ftw;
            r_dwell_cnt <= '0;
            r_state     <= avs_writedata[2] ? S_SWEEP : S_RUN;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_acc <= '0;
               end
               S_RUN: begin
                  // Live FTW lets software hop frequency without a restart
                  r_acc <= r_acc + r_ftw;
               end
               S_SWEEP: begin
                  r_acc <= r_acc + r_cur_ftw;
                  if (w_dwell_exp) begin
                     r_dwell_cnt <= '0;
                     if (r_cur_ftw >= r_ftw_end) begin
                        if (r_repeat) begin
                           r_cur_ftw <= r_ftw;
                        end else begin
                           r_state <= S_FIN;
                           r_done  <= 1'b1;
                        end
                     end else begin
                        r_cur_ftw <= w_next_ftw;
                     end
                  end else begin
                     r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                  end
               end
               S_FIN: begin
                  r_acc <= r_acc;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
